// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
// Optional WAIT_READY timeout is enabled with RST_SEQ_TIMEOUT_EN.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_REASSERT
  } rst_seq_state_e;

  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable saturating up-counter with clear, enable and terminal match.
// Shared by every timed state of the reset sequencer.
module rst_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] term_i,
  output logic         match_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == term_i);

endmodule

// File: rtl/rst_seq.sv
// Staged reset release sequencer with software reassert handshake.
// Define RST_SEQ_TIMEOUT_EN to bound each WAIT_READY by ACK_TIMEOUT.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  output logic [NUM_STAGES-1:0]             stage_rst_o,
  input  logic [NUM_STAGES-1:0]             stage_ready_i,
  output logic [cnt_width(NUM_STAGES)-1:0]  stage_idx_o,
  output logic                              done_o,
  output logic                              timeout_o,
  input  logic                              sw_req_i,
  output logic                              sw_ack_o
);

  localparam int IW = cnt_width(NUM_STAGES);
  localparam int CW = cnt_width(max3(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT));
  localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_T  = CW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [IW-1:0] LAST   = IW'(NUM_STAGES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] ACK_T  = CW'(ACK_TIMEOUT - 1);
`endif

  rst_seq_state_e state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] srst_q, srst_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  tmo_q, tmo_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt_term;
  logic          cnt_match;
  logic          rdy_sel;
  logic          adv;

  rst_seq_cnt #(
    .W (CW)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .term_i     (cnt_term),
    .match_o    (cnt_match)
  );

  // Only the stage being released is ever looked at.
  always_comb begin
    rdy_sel = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx_q == IW'(k)) rdy_sel = stage_ready_i[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    srst_d   = srst_q;
    done_d   = done_q;
    ack_d    = 1'b0;
    tmo_d    = tmo_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = HOLD_T;
    adv      = 1'b0;
    unique case (state_q)
      S_HOLD, S_REASSERT: begin
        cnt_en = 1'b1;
        if (cnt_match) begin
          cnt_clr = 1'b1;
          state_d = S_RELEASE;
          ack_d   = (state_q == S_REASSERT);
        end
      end
      S_RELEASE: begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (idx_q == IW'(k)) srst_d[k] = 1'b0;
        end
        cnt_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef RST_SEQ_TIMEOUT_EN
        cnt_en   = 1'b1;
        cnt_term = ACK_T;
        adv      = rdy_sel | cnt_match;
        if (!rdy_sel && cnt_match) tmo_d = 1'b1;
`else
        adv      = rdy_sel;
`endif
        if (adv) begin
          cnt_clr = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (STAGE_GAP == 0) begin
            state_d = S_RELEASE;
            idx_d   = idx_q + IW'(1);
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        cnt_en   = 1'b1;
        cnt_term = GAP_T;
        if (cnt_match) begin
          cnt_clr = 1'b1;
          state_d = S_RELEASE;
          idx_d   = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (sw_req_i) begin
          state_d = S_REASSERT;
          srst_d  = '1;
          done_d  = 1'b0;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_HOLD;
      idx_q   <= '0;
      srst_q  <= '1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      srst_q  <= srst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
    end
  end

  assign stage_rst_o = srst_q;
  assign stage_idx_o = idx_q;
  assign done_o      = done_q;
  assign sw_ack_o    = ack_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign timeout_o   = tmo_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Randomised and directed bench for rst_seq against an event-time model.
// Honours RST_SEQ_TIMEOUT_EN when it is defined for the build.
module tb_rst_seq;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int ACK  = 64;
`ifdef RST_SEQ_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         sw_req_i = 1'b0;
  logic [N-1:0] stage_ready_i = '1;
  logic [N-1:0] stage_rst_o;
  logic [2:0]   stage_idx_o;
  logic         done_o, timeout_o, sw_ack_o;

  logic [0:0] u1_ready = 1'b0;
  logic [0:0] u1_srst;
  logic [0:0] u1_idx;
  logic       u1_done, u1_to, u1_ack;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_STAGES (N),
    .HOLD_CYCLES(HOLD),
    .STAGE_GAP  (GAP),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stage_rst_o  (stage_rst_o),
    .stage_ready_i(stage_ready_i),
    .stage_idx_o  (stage_idx_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .sw_req_i     (sw_req_i),
    .sw_ack_o     (sw_ack_o)
  );

  rst_seq #(
    .NUM_STAGES (1),
    .HOLD_CYCLES(HOLD),
    .STAGE_GAP  (0),
    .ACK_TIMEOUT(ACK)
  ) u1 (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stage_rst_o  (u1_srst),
    .stage_ready_i(u1_ready),
    .stage_idx_o  (u1_idx),
    .done_o       (u1_done),
    .timeout_o    (u1_to),
    .sw_req_i     (1'b0),
    .sw_ack_o     (u1_ack)
  );

  int vec = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: schedules release/ack edges as absolute edge numbers.
  int         m_n = 0;
  int         m_k = 0;
  int         m_rel = -1;
  int         m_wst = 0;
  int         m_idx_at = -1;
  int         m_ack_at = -1;
  bit         m_wait = 1'b0;
  bit         m_dn = 1'b0;
  bit         m_to = 1'b0;
  bit         m_ak = 1'b0;
  logic [N-1:0] m_sr = '1;
  int         m_ix = 0;

  task automatic model_step();
    bit rdy, hit_to;
    m_n++;
    if (rst_i) begin
      m_sr = '1; m_dn = 0; m_to = 0; m_ak = 0; m_ix = 0;
      m_k = 0; m_wait = 0;
      m_rel = m_n + 1 + HOLD;
      m_idx_at = -1; m_ack_at = -1;
    end else begin
      m_ak = (m_n == m_ack_at);
      if (m_n == m_rel) begin
        m_sr[m_k] = 1'b0;
        m_wait = 1;
        m_wst = m_n + 1;
      end else if (m_wait) begin
        rdy = stage_ready_i[m_k];
        hit_to = TMO && !rdy && (m_n - m_wst == ACK - 1);
        if (rdy || hit_to) begin
          if (hit_to) m_to = 1;
          m_wait = 0;
          if (m_k == N - 1) begin
            m_dn = 1;
          end else begin
            m_k++;
            m_rel = m_n + GAP + 1;
            m_idx_at = m_rel - 1;
          end
        end
      end else if (m_dn && sw_req_i) begin
        m_dn = 0; m_sr = '1; m_k = 0; m_ix = 0;
        m_rel = m_n + HOLD + 1;
        m_ack_at = m_n + HOLD;
        m_idx_at = -1;
      end
      if (m_n == m_idx_at) m_ix = m_k;
    end
  endtask

  int           e_cnt = -1;
  int           fall_e[N];
  int           to_e = -1;
  logic [N-1:0] prev_sr = '1;
  logic         prev_to = 1'b0;

  task automatic tick();
    @(posedge clk);
    e_cnt = rst_i ? -1 : e_cnt + 1;
    model_step();
    @(negedge clk);
    chk("stage_rst", 32'(stage_rst_o), 32'(m_sr));
    chk("done", 32'(done_o), 32'(m_dn));
    chk("idx", 32'(stage_idx_o), 32'(m_ix));
    chk("ack", 32'(sw_ack_o), 32'(m_ak));
    chk("timeout", 32'(timeout_o), 32'(m_to));
    for (int b = 0; b < N; b++) begin
      if (e_cnt < 0) fall_e[b] = -1;
      else if (prev_sr[b] && !stage_rst_o[b]) fall_e[b] = e_cnt;
    end
    if (e_cnt < 0) to_e = -1;
    else if (timeout_o && !prev_to) to_e = e_cnt;
    prev_sr = stage_rst_o;
    prev_to = timeout_o;
  endtask

  task automatic run_until_done(input int lim, input string tag);
    int i = 0;
    while (!done_o && i < lim) begin
      tick();
      i++;
    end
    chk(tag, 32'(done_o), 32'd1);
  endtask

  task automatic do_reset(input logic [N-1:0] rdy);
    rst_i = 1'b1;
    stage_ready_i = rdy;
    sw_req_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  int acks;
  int ack_tick;

  initial begin
    for (int b = 0; b < N; b++) fall_e[b] = -1;
    do_reset('1);

    // Basic release order, plus the single-stage no-gap instance.
    for (int i = 0; i < 40; i++) begin
      tick();
      if (e_cnt == 12) begin
        chk("u1_srst", 32'(u1_srst), 32'd0);
        chk("u1_done_early", 32'(u1_done), 32'd0);
        u1_ready = 1'b1;
      end
      if (e_cnt == 13) begin
        chk("u1_done", 32'(u1_done), 32'd1);
        chk("u1_idx", 32'(u1_idx), 32'd0);
      end
    end
    chk("fall0", 32'(fall_e[0]), 32'd8);
    chk("fall1", 32'(fall_e[1]), 32'd14);
    chk("fall3", 32'(fall_e[3]), 32'd26);
    chk("done_basic", 32'(done_o), 32'd1);

    // Stage 2 ready held off.
    do_reset(4'b1011);
    for (int i = 0; i < 41; i++) tick();
    chk("s3_held", 32'(stage_rst_o[3]), 32'd1);
    chk("no_tmo", 32'(timeout_o), 32'd0);
    stage_ready_i = '1;
    run_until_done(60, "done_late");
    chk("fall3_gap", 32'(fall_e[3]), 32'd46);

    // Stage 1 never ready.
    do_reset(4'b1101);
`ifdef RST_SEQ_TIMEOUT_EN
    run_until_done(200, "done_tmo");
    chk("to_edge", 32'(to_e), 32'd78);
    chk("to_flag", 32'(timeout_o), 32'd1);
`else
    repeat (120) tick();
    chk("stuck", 32'(done_o), 32'd0);
    chk("to_zero", 32'(timeout_o), 32'd0);
    stage_ready_i = '1;
    run_until_done(60, "done_unstuck");
`endif

    // Software reassert from DONE.
    stage_ready_i = '1;
    sw_req_i = 1'b1;
    acks = 0;
    ack_tick = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sw_ack_o) begin
        acks++;
        sw_req_i = 1'b0;
        if (ack_tick == 0) ack_tick = i + 1;
      end
    end
    run_until_done(60, "done_rerun");
    chk("ack_count", 32'(acks), 32'd1);
    chk("ack_delay", 32'(ack_tick), 32'd9);

    // Request outside DONE, then reset in the middle of a gap.
    do_reset('1);
    for (int i = 0; i < 9; i++) tick();
    sw_req_i = 1'b1;
    repeat (3) tick();
    sw_req_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("gap_idx", 32'(stage_idx_o), 32'd1);
    rst_i = 1'b1;
    tick();
    chk("midgap_srst", 32'(stage_rst_o), 32'hF);
    chk("midgap_done", 32'(done_o), 32'd0);
    chk("midgap_idx", 32'(stage_idx_o), 32'd0);
    rst_i = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < N; b++) begin
        stage_ready_i[b] = ($urandom_range(0, 2) == 0);
      end
      if (sw_ack_o) sw_req_i = 1'b0;
      else if ($urandom_range(0, 19) == 0) sw_req_i = 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
